button_event_queue: RTL and testbench

- Memory-mapped input stage that feeds the CPU's button read path at dmem address 0; replaces the current level-only button encoder.
- Synchronises and debounces BTNU/BTNR/BTND/BTNL, turns each debounced press into a 3-bit event code, and queues codes in a small FIFO.
- The CPU load from address 0 returns the head code and pops it, so no press is lost between polls.

---
 rtl/button_event_queue.sv | 177 +++++++++++++++++
 tb/tb_button_event_queue.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/button_event_queue.sv
// Debounced four-button press detector feeding a small event FIFO popped by CPU loads.
// Optional auto-repeat while a button is held: define BTN_AUTOREPEAT_EN.
module button_event_queue #(
  parameter int unsigned DEBOUNCE_CYCLES = 290000,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned REPEAT_CYCLES   = 14500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       BTNU,
  input  logic       BTNR,
  input  logic       BTND,
  input  logic       BTNL,
  input  logic       rd_en,
  output logic [2:0] button,
  output logic       empty,
  output logic       full,
  output logic       overflow
);

  localparam int unsigned NUM_BTN = 4;
  localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned COUNT_W = PTR_W + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
    $error("button_event_queue: illegal parameter value");
  end

  logic [NUM_BTN-1:0] w_raw;
  logic [NUM_BTN-1:0] r_sync1;
  logic [NUM_BTN-1:0] r_sync2;
  logic [NUM_BTN-1:0] r_stable;
  logic [NUM_BTN-1:0] r_stable_d;
  logic [CNT_W-1:0]   r_cnt [NUM_BTN];
  logic [NUM_BTN-1:0] w_rise;
  logic [NUM_BTN-1:0] w_set;
  logic [NUM_BTN-1:0] r_pending;
  logic [NUM_BTN-1:0] w_grant;
  logic [2:0]         w_code;
  logic               w_collide;
  logic               r_overflow;

  logic [2:0]         r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [COUNT_W-1:0] r_count;
  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_push;

  // Bit index doubles as priority: 0=U (highest) .. 3=L.
  assign w_raw = {BTNL, BTND, BTNR, BTNU};

  // Synchroniser and per-button debounce.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_stable   <= '0;
      r_stable_d <= '0;
      for (int i = 0; i < int'(NUM_BTN); i++) r_cnt[i] <= '0;
    end else begin
      r_sync1    <= w_raw;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      for (int i = 0; i < int'(NUM_BTN); i++) begin
        if (r_sync2[i] != r_stable[i]) begin
          if (r_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_stable[i] <= ~r_stable[i];
            r_cnt[i]    <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_rise = r_stable & ~r_stable_d;

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_CYCLES);

  logic [REP_W-1:0]   r_rep_cnt [NUM_BTN];
  logic [NUM_BTN-1:0] w_rep_pulse;

  // Held button re-arms its pending bit every REPEAT_CYCLES after the press event.
  always_comb begin
    w_rep_pulse = '0;
    for (int i = 0; i < int'(NUM_BTN); i++) begin
      w_rep_pulse[i] = r_stable[i] & r_stable_d[i] &
                       (r_rep_cnt[i] == REP_W'(REPEAT_CYCLES - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_BTN); i++) r_rep_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_BTN); i++) begin
        if (r_stable[i] & r_stable_d[i]) begin
          r_rep_cnt[i] <= w_rep_pulse[i] ? '0 : r_rep_cnt[i] + REP_W'(1);
        end else begin
          r_rep_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_set = w_rise | w_rep_pulse;
`else
  assign w_set = w_rise;
`endif

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == COUNT_W'(FIFO_DEPTH));
  assign w_pop   = rd_en & ~w_empty;
  // A pop in the same cycle frees the slot the push will use.
  assign w_push  = (|r_pending) & (~w_full | rd_en);

  // Fixed-priority pick of the lowest-index pending button.
  always_comb begin
    w_grant = '0;
    w_code  = 3'd0;
    for (int i = int'(NUM_BTN) - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_grant    = '0;
        w_grant[i] = w_push;
        w_code     = 3'(i + 1);
      end
    end
  end

  assign w_collide = |(w_set & r_pending & ~w_grant);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_grant) | w_set;
      if (w_collide) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + COUNT_W'(1);
        2'b01:   r_count <= r_count - COUNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: an empty FIFO masks the head entry.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= w_code;
  end

  assign button   = w_empty ? 3'd0 : r_mem[r_head];
  assign empty    = w_empty;
  assign full     = w_full;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_button_event_queue.sv
// Directed bench for button_event_queue with a scoreboard of expected event codes.
`timescale 1ns/1ps
module tb_button_event_queue;

  localparam int unsigned DEB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned REP   = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       BTNU = 1'b0, BTNR = 1'b0, BTND = 1'b0, BTNL = 1'b0;
  logic       rd_en = 1'b0;
  logic [2:0] button;
  logic       empty, full, overflow;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];

  button_event_queue #(
    .DEBOUNCE_CYCLES(DEB),
    .FIFO_DEPTH     (DEPTH),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .BTNU    (BTNU),
    .BTNR    (BTNR),
    .BTND    (BTND),
    .BTNL    (BTNL),
    .rd_en   (rd_en),
    .button  (button),
    .empty   (empty),
    .full    (full),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Compare head with the scoreboard front, then pulse rd_en for one cycle.
  task automatic pop_expect(input string tag);
    logic [2:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'd0;
    check(tag, 32'(button), 32'(e));
    check({tag, "_empty"}, 32'(empty), 32'(e == 3'd0));
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  // Clean press and release of button d (0=U..3=L), each phase fully debounced.
  task automatic tap(input int d, input bit expect_code);
    case (d)
      0: BTNU = 1'b1;
      1: BTNR = 1'b1;
      2: BTND = 1'b1;
      default: BTNL = 1'b1;
    endcase
    if (expect_code) exp_q.push_back(3'(d + 1));
    tick(8);
    BTNU = 1'b0; BTNR = 1'b0; BTND = 1'b0; BTNL = 1'b0;
    tick(8);
  endtask

  initial begin
    // Reset held with BTNU high
    BTNU = 1'b1;
    tick(2);
    check("rst_button", 32'(button), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b1;
    exp_q.push_back(3'd1);
    tick(7);
    check("rst_lat_early", 32'(empty), 32'd1);
    tick(1);
    pop_expect("rst_first_u");
    check("rst_drained", 32'(empty), 32'd1);
    BTNU = 1'b0;
    tick(8);

    // Bounce on BTNR then stable high
    BTNR = 1'b1; tick(1);
    BTNR = 1'b0; tick(1);
    BTNR = 1'b1; tick(1);
    BTNR = 1'b0; tick(1);
    BTNR = 1'b1;
    exp_q.push_back(3'd2);
    tick(7);
    check("bounce_early", 32'(empty), 32'd1);
    tick(1);
    pop_expect("bounce_r");
    BTNR = 1'b0;
    tick(10);
    check("release_no_event", 32'(empty), 32'd1);
    check("release_button0", 32'(button), 32'd0);

    // Simultaneous U and L: U first
    BTNU = 1'b1; BTNL = 1'b1;
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd4);
    tick(9);
    pop_expect("prio_u");
    pop_expect("prio_l");
    pop_expect("prio_empty");
    BTNU = 1'b0; BTNL = 1'b0;
    tick(8);

    // Fill FIFO with D, one pending, one lost
    for (int n = 0; n < 4; n++) tap(2, 1'b1);
    check("full_after4", 32'(full), 32'd1);
    check("no_ovf_after4", 32'(overflow), 32'd0);
    tap(2, 1'b1);
    check("full_pending", 32'(full), 32'd1);
    check("no_ovf_pending", 32'(overflow), 32'd0);
    tap(2, 1'b0);
    check("ovf_set", 32'(overflow), 32'd1);
    pop_expect("full_pop0");
    check("full_refill", 32'(full), 32'd1);
    for (int n = 0; n < 4; n++) pop_expect("full_drain");
    check("drain_empty", 32'(empty), 32'd1);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Pop on empty is ignored
    pop_expect("empty_pop");
    check("empty_pop_button", 32'(button), 32'd0);
    check("empty_pop_full", 32'(full), 32'd0);
    tap(3, 1'b1);
    pop_expect("after_empty_pop_l");
    check("after_empty_pop_e", 32'(empty), 32'd1);

    // Long hold of BTND
    BTND = 1'b1;
    exp_q.push_back(3'd3);
`ifdef BTN_AUTOREPEAT_EN
    exp_q.push_back(3'd3);
    exp_q.push_back(3'd3);
`endif
    tick(44);
    BTND = 1'b0;
    tick(10);
`ifdef BTN_AUTOREPEAT_EN
    pop_expect("hold_d0");
    pop_expect("hold_d1");
    pop_expect("hold_d2");
`else
    pop_expect("hold_d0");
`endif
    pop_expect("hold_end");
    check("hold_ovf", 32'(overflow), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
